axi_dma_read_master: RTL and testbench

//  AXI read-side DMA engine that sits upstream of the AXI slave memory model and drives its AR channel.

---
 rtl/axi_dma_read_master_if.sv | 44 ++++
 rtl/axi_dma_read_master.sv | 138 +++++++++++++
 tb/tb_axi_dma_read_master.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_read_master_if.sv
// AR, R and output-stream signal bundle for the DMA read master.
// master = DMA engine side, slave = memory model / stream sink side.
interface axi_dma_read_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   logic                  arvalid_o;
   logic [ID_WIDTH-1:0]   arid_o;
   logic [ADDR_WIDTH-1:0] araddr_o;
   logic [3:0]            arlen_o;
   logic [2:0]            arsize_o;
   logic [1:0]            arburst_o;
   logic                  arready_i;
   logic                  rvalid_i;
   logic [ID_WIDTH-1:0]   rid_i;
   logic [DATA_WIDTH-1:0] rdata_i;
   logic [1:0]            rresp_i;
   logic                  rlast_i;
   logic                  rready_o;
   logic                  dvalid_o;
   logic [DATA_WIDTH-1:0] ddata_o;
   logic                  dready_i;

   modport master (
      output arvalid_o, arid_o, araddr_o, arlen_o,
      output arsize_o, arburst_o,
      input  arready_i,
      input  rvalid_i, rid_i, rdata_i, rresp_i, rlast_i,
      output rready_o,
      output dvalid_o, ddata_o,
      input  dready_i
   );

   modport slave (
      input  arvalid_o, arid_o, araddr_o, arlen_o,
      input  arsize_o, arburst_o,
      output arready_i,
      output rvalid_i, rid_i, rdata_i, rresp_i, rlast_i,
      input  rready_o,
      input  dvalid_o, ddata_o,
      output dready_i
   );
endinterface

// File: rtl/axi_dma_read_master.sv
// AXI read DMA: splits a byte range into 4KB-safe INCR bursts (<=16 beats),
// one burst outstanding, R beats passed straight through to a stream.
module axi_dma_read_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter logic [ID_WIDTH-1:0] ARID_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] src_addr_i,
   input  logic [15:0]           byte_len_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   axi_dma_read_master_if.master bus
);
   localparam int BPB     = DATA_WIDTH / 8;
   localparam int LOG_BPB = $clog2(BPB);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_RD, S_DONE} state_t;

   state_t                state, next;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [15:0]           left_q;
   logic [4:0]            cnt_q;
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic [3:0]            arlen_q;
   logic                  err_q;

   logic [15:0]           req_beats;
   logic [ADDR_WIDTH-1:0] src_addr;
   logic [15:0]           src_left;
   logic [12:0]           room_bytes;
   logic [12:0]           room;
   logic [4:0]            blen;
   logic [4:0]            ar_beats;
   logic                  enter_ar;
   logic                  hs_ar;
   logic                  hs_r;
   logic                  beat_bad;

   assign req_beats = byte_len_i >> LOG_BPB;
   assign ar_beats  = {1'b0, arlen_q} + 5'd1;
   assign hs_ar     = (state == S_AR) && bus.arready_i;
   assign hs_r      = (state == S_RD) && bus.rvalid_i && bus.dready_i;
   assign beat_bad  = (bus.rresp_i != 2'b00)
                    || (bus.rid_i != ARID_VAL)
                    || (bus.rlast_i != (cnt_q == 5'd1));

   // Size of the next burst: remaining beats, 16, and distance to the 4KB page end.
   always_comb begin
      src_addr   = (state == S_IDLE) ? src_addr_i : addr_q;
      src_left   = (state == S_IDLE) ? req_beats : left_q;
      room_bytes = 13'd4096 - {1'b0, src_addr[11:0]};
      room       = room_bytes >> LOG_BPB;
      blen       = 5'd16;
      if (src_left < 16'd16) blen = src_left[4:0];
      if (room < 13'(blen)) blen = room[4:0];
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next;
   end

   // Next-state logic and the handshake-facing outputs.
   always_comb begin
      next         = state;
      enter_ar     = 1'b0;
      busy_o       = (state != S_IDLE);
      done_o       = (state == S_DONE);
      bus.arvalid_o = (state == S_AR);
      bus.rready_o = (state == S_RD) && bus.dready_i;
      bus.dvalid_o = (state == S_RD) && bus.rvalid_i;
      bus.ddata_o  = (state == S_RD) ? bus.rdata_i : '0;
      unique case (state)
         S_IDLE: if (start_i) begin
            if (req_beats == 16'd0) begin
               next = S_DONE;
            end else begin
               next     = S_AR;
               enter_ar = 1'b1;
            end
         end
         S_AR: if (bus.arready_i) next = S_RD;
         S_RD: if (hs_r && cnt_q == 5'd1) begin
            if (left_q == 16'd0) begin
               next = S_DONE;
            end else begin
               next     = S_AR;
               enter_ar = 1'b1;
            end
         end
         S_DONE: next = S_IDLE;
      endcase
   end

   // Transfer bookkeeping: address, remaining beats, burst counter, error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         left_q   <= '0;
         cnt_q    <= '0;
         araddr_q <= '0;
         arlen_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == S_IDLE && start_i) begin
            addr_q <= src_addr_i;
            left_q <= req_beats;
            err_q  <= 1'b0;
         end
         if (enter_ar) begin
            araddr_q <= src_addr;
            arlen_q  <= 4'(blen - 5'd1);
         end
         if (hs_ar) begin
            addr_q <= addr_q + (ADDR_WIDTH'(ar_beats) << LOG_BPB);
            left_q <= left_q - 16'(ar_beats);
            cnt_q  <= ar_beats;
         end
         if (hs_r) begin
            cnt_q <= cnt_q - 5'd1;
            if (beat_bad) err_q <= 1'b1;
         end
      end
   end

   assign err_o         = err_q;
   assign bus.araddr_o  = araddr_q;
   assign bus.arlen_o   = arlen_q;
   assign bus.arid_o    = ARID_VAL;
   assign bus.arsize_o  = 3'(LOG_BPB);
   assign bus.arburst_o = 2'b01;
endmodule

// File: tb/tb_axi_dma_read_master.sv
// Directed bench for axi_dma_read_master: memory model returns
// data equal to the beat byte address so ordering is checkable.
module tb_axi_dma_read_master;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [15:0]   byte_len = '0;
   logic          busy, done, err;

   int total = 0;
   int bad = 0;

   logic [AW-1:0] sb_addr[$];
   int            sb_len[$];
   logic [AW-1:0] log_addr[$];
   int            log_len[$];
   logic [DW-1:0] rx_q[$];
   int bi = 0, gbeat = 0, ar_wait = 0, ar_delay = 0, err_at = -1;
   int done_cnt = 0, rr_bad = 0, ar_unstable = 0, first_err = -1;
   logic [AW-1:0] hold_a = '0;
   int            hold_l = 0;
   bit            rand_dready = 1'b0;

   axi_dma_read_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

   axi_dma_read_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .ARID_VAL(4'd0)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start), .src_addr_i(src_addr),
      .byte_len_i(byte_len), .busy_o(busy), .done_o(done), .err_o(err),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Memory model: AR acceptance with programmable delay, in-order R bursts.
   initial begin
      bus.arready_i = 1'b0;
      bus.rvalid_i  = 1'b0;
      bus.rid_i     = '0;
      bus.rdata_i   = '0;
      bus.rresp_i   = 2'b00;
      bus.rlast_i   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.arvalid_o) begin
               if (ar_wait > 0 && (bus.araddr_o !== hold_a || int'(bus.arlen_o) != hold_l))
                  ar_unstable++;
               hold_a = bus.araddr_o;
               hold_l = int'(bus.arlen_o);
               if (bus.arready_i) begin
                  sb_addr.push_back(bus.araddr_o);
                  sb_len.push_back(int'(bus.arlen_o));
                  log_addr.push_back(bus.araddr_o);
                  log_len.push_back(int'(bus.arlen_o));
                  ar_wait = 0;
               end else begin
                  ar_wait++;
               end
            end
            if (bus.rvalid_i && bus.rready_o) begin
               bi++;
               gbeat++;
               if (bi > sb_len[0]) begin
                  void'(sb_addr.pop_front());
                  void'(sb_len.pop_front());
                  bi = 0;
               end
            end
         end
         @(posedge clk);
         #1;
         if (rst) begin
            sb_addr.delete();
            sb_len.delete();
            bi = 0;
            ar_wait = 0;
            bus.arready_i = 1'b0;
            bus.rvalid_i  = 1'b0;
            bus.rlast_i   = 1'b0;
            bus.rresp_i   = 2'b00;
         end else begin
            bus.arready_i = bus.arvalid_o && (ar_wait >= ar_delay);
            if (sb_addr.size() > 0) begin
               bus.rvalid_i = 1'b1;
               bus.rdata_i  = sb_addr[0] + AW'(bi * 4);
               bus.rlast_i  = (bi == sb_len[0]);
               bus.rresp_i  = (gbeat == err_at) ? 2'b10 : 2'b00;
               bus.rid_i    = '0;
            end else begin
               bus.rvalid_i = 1'b0;
               bus.rlast_i  = 1'b0;
               bus.rresp_i  = 2'b00;
            end
         end
      end
   end

   // Stream sink and monitors.
   initial begin
      bus.dready_i = 1'b0;
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (err && first_err < 0) first_err = rx_q.size();
         if (bus.dvalid_o && bus.rready_o !== bus.dready_i) rr_bad++;
         if (bus.dvalid_o && bus.dready_i) rx_q.push_back(bus.ddata_o);
         @(posedge clk);
         #1;
         bus.dready_i = rand_dready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   function automatic int rx_mismatch(input logic [AW-1:0] base, input int n);
      int m = 0;
      if (rx_q.size() != n) return -1;
      for (int i = 0; i < n; i++)
         if (rx_q[i] !== base + AW'(i * 4)) m++;
      return m;
   endfunction

   task automatic kick(input logic [AW-1:0] a, input logic [15:0] l);
      log_addr.delete();
      log_len.delete();
      rx_q.delete();
      done_cnt = 0;
      first_err = -1;
      gbeat = 0;
      rr_bad = 0;
      ar_unstable = 0;
      @(negedge clk);
      src_addr = a;
      byte_len = l;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int maxc);
      int n = 0;
      while (done_cnt == 0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (done_cnt == 0) begin
         bad++;
         $display("FAIL %s_timeout: done_o not seen in %0d cycles", nm, maxc);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done, err} !== 3'b000) begin
         bad++;
         $display("FAIL rst_status: got %b want 000", {busy, done, err});
      end
      total++;
      if ({bus.arvalid_o, bus.rready_o, bus.dvalid_o} !== 3'b000) begin
         bad++;
         $display("FAIL rst_valids: got %b want 000",
                  {bus.arvalid_o, bus.rready_o, bus.dvalid_o});
      end
      total++;
      if (bus.araddr_o !== 32'h0 || bus.arlen_o !== 4'h0 || bus.ddata_o !== 32'h0) begin
         bad++;
         $display("FAIL rst_regs: got %h/%h/%h want 0/0/0",
                  bus.araddr_o, bus.arlen_o, bus.ddata_o);
      end
      total++;
      if (bus.arsize_o !== 3'd2 || bus.arburst_o !== 2'b01 || bus.arid_o !== 4'd0) begin
         bad++;
         $display("FAIL rst_const: got %h/%h/%h want 2/1/0",
                  bus.arsize_o, bus.arburst_o, bus.arid_o);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      int m;
      kick(32'h0, 16'd64);
      wait_done("t1", 400);
      total++;
      if (log_addr.size() != 1 || log_addr[0] !== 32'h0 || log_len[0] != 15) begin
         bad++;
         $display("FAIL t1_ar: got n=%0d want one AR 0x0 len 15", log_addr.size());
      end
      m = rx_mismatch(32'h0, 16);
      total++;
      if (m != 0) begin
         bad++;
         $display("FAIL t1_data: got mismatch=%0d rx=%0d want 0 of 16", m, rx_q.size());
      end
      total++;
      if (done_cnt != 1 || err !== 1'b0) begin
         bad++;
         $display("FAIL t1_done: got done=%0d err=%b want 1/0", done_cnt, err);
      end
   endtask

   task automatic test_multi();
      int m;
      kick(32'h100, 16'd256);
      wait_done("t2", 800);
      total++;
      if (log_addr.size() != 4) begin
         bad++;
         $display("FAIL t2_ar_count: got %0d want 4", log_addr.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (log_addr[i] !== 32'h100 + 32'(i * 64) || log_len[i] != 15) begin
               bad++;
               $display("FAIL t2_ar%0d: got %h/%0d want %h/15",
                        i, log_addr[i], log_len[i], 32'h100 + 32'(i * 64));
            end
         end
      end
      m = rx_mismatch(32'h100, 64);
      total++;
      if (m != 0 || err !== 1'b0 || done_cnt != 1) begin
         bad++;
         $display("FAIL t2_data: got mismatch=%0d err=%b done=%0d want 0/0/1",
                  m, err, done_cnt);
      end
   endtask

   task automatic test_4k_split();
      int m;
      kick(32'hFF8, 16'd32);
      wait_done("t3", 400);
      total++;
      if (log_addr.size() != 2) begin
         bad++;
         $display("FAIL t3_ar_count: got %0d want 2", log_addr.size());
      end else begin
         total++;
         if (log_addr[0] !== 32'hFF8 || log_len[0] != 1) begin
            bad++;
            $display("FAIL t3_ar0: got %h/%0d want ff8/1", log_addr[0], log_len[0]);
         end
         total++;
         if (log_addr[1] !== 32'h1000 || log_len[1] != 5) begin
            bad++;
            $display("FAIL t3_ar1: got %h/%0d want 1000/5", log_addr[1], log_len[1]);
         end
      end
      m = rx_mismatch(32'hFF8, 8);
      total++;
      if (m != 0) begin
         bad++;
         $display("FAIL t3_data: got mismatch=%0d rx=%0d want 0 of 8", m, rx_q.size());
      end
   endtask

   task automatic test_backpressure();
      int m;
      ar_delay = 3;
      rand_dready = 1'b1;
      kick(32'h100, 16'd256);
      wait_done("t4", 3000);
      ar_delay = 0;
      rand_dready = 1'b0;
      m = rx_mismatch(32'h100, 64);
      total++;
      if (m != 0) begin
         bad++;
         $display("FAIL t4_data: got mismatch=%0d rx=%0d want 0 of 64", m, rx_q.size());
      end
      total++;
      if (rr_bad != 0) begin
         bad++;
         $display("FAIL t4_rready: got %0d cycles rready!=dready want 0", rr_bad);
      end
      total++;
      if (ar_unstable != 0 || log_addr.size() != 4) begin
         bad++;
         $display("FAIL t4_ar: got unstable=%0d n=%0d want 0/4",
                  ar_unstable, log_addr.size());
      end
   endtask

   task automatic test_rresp_err();
      int m;
      err_at = 2;
      kick(32'h0, 16'd64);
      wait_done("t5", 400);
      err_at = -1;
      total++;
      if (first_err != 3) begin
         bad++;
         $display("FAIL t5_err_rise: got err after %0d beats want 3", first_err);
      end
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL t5_err_held: got %b want 1", err);
      end
      m = rx_mismatch(32'h0, 16);
      total++;
      if (m != 0 || done_cnt != 1) begin
         bad++;
         $display("FAIL t5_data: got mismatch=%0d done=%0d want 0/1", m, done_cnt);
      end
   endtask

   task automatic test_err_clear_and_ignore();
      int m;
      kick(32'h300, 16'd16);
      @(negedge clk);
      src_addr = 32'h9000;
      byte_len = 16'd64;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("clr", 400);
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL clr_err: got %b want 0", err);
      end
      total++;
      if (log_addr.size() != 1 || log_addr[0] !== 32'h300 || log_len[0] != 3) begin
         bad++;
         $display("FAIL busy_ignore_ar: got n=%0d want one AR 300/3", log_addr.size());
      end
      m = rx_mismatch(32'h300, 4);
      total++;
      if (m != 0 || done_cnt != 1) begin
         bad++;
         $display("FAIL busy_ignore_data: got mismatch=%0d done=%0d want 0/1", m, done_cnt);
      end
   endtask

   task automatic test_zero_len();
      kick(32'h500, 16'd0);
      wait_done("zero", 50);
      total++;
      if (log_addr.size() != 0 || rx_q.size() != 0 || done_cnt != 1) begin
         bad++;
         $display("FAIL zero_len: got ar=%0d rx=%0d done=%0d want 0/0/1",
                  log_addr.size(), rx_q.size(), done_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int m;
      kick(32'h0, 16'd64);
      while (rx_q.size() < 4 && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (rx_q.size() < 4) begin
         bad++;
         $display("FAIL t6_wait: got %0d beats want 4", rx_q.size());
      end
      rst = 1'b1;
      #1;
      total++;
      if ({busy, done, err, bus.arvalid_o, bus.rready_o, bus.dvalid_o} !== 6'b0) begin
         bad++;
         $display("FAIL t6_rst_outs: got %b want 000000",
                  {busy, done, err, bus.arvalid_o, bus.rready_o, bus.dvalid_o});
      end
      total++;
      if (bus.araddr_o !== 32'h0 || bus.arlen_o !== 4'h0 || bus.ddata_o !== 32'h0) begin
         bad++;
         $display("FAIL t6_rst_regs: got %h/%h/%h want 0/0/0",
                  bus.araddr_o, bus.arlen_o, bus.ddata_o);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      kick(32'h40, 16'd8);
      wait_done("t6", 200);
      m = rx_mismatch(32'h40, 2);
      total++;
      if (m != 0 || err !== 1'b0 || done_cnt != 1) begin
         bad++;
         $display("FAIL t6_restart: got mismatch=%0d err=%b done=%0d want 0/0/1",
                  m, err, done_cnt);
      end
      total++;
      if (log_addr.size() != 1 || log_addr[0] !== 32'h40 || log_len[0] != 1) begin
         bad++;
         $display("FAIL t6_ar: got n=%0d want one AR 40/1", log_addr.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_4k_split();
      test_backpressure();
      test_rresp_err();
      test_err_clear_and_ignore();
      test_zero_len();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
